// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: runs conv_engine over NUM_FILTERS 5x5 filters and relocates write-backs; watchdog under CONV_SEQ_WATCHDOG_EN
module conv_layer_sequencer #(
    parameter int MAPSIZE = 32,
    parameter int NUM_FILTERS = 6,
    parameter int WDOG_CYCLES = 4096,
    localparam int OUTPUT_DIM = MAPSIZE - 4,
    localparam int TOTAL_PIXELS = MAPSIZE * MAPSIZE,
    localparam int OUT_PIXELS = OUTPUT_DIM * OUTPUT_DIM,
    localparam int WA = $clog2(NUM_FILTERS * 25),
    localparam int IA = $clog2(TOTAL_PIXELS),
    localparam int EA = $clog2(OUT_PIXELS),
    localparam int OA = $clog2(NUM_FILTERS * OUT_PIXELS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    output logic                         busy,
    output logic                         layer_done,
    output logic                         err,
    output logic [WA-1:0]                wgt_rd_addr,
    input  logic signed [7:0]            wgt_rd_data,
    output logic [IA-1:0]                img_rd_addr,
    output logic                         img_rd_en,
    input  logic signed [7:0]            img_rd_data,
    output logic                         eng_start,
    output logic                         eng_data_valid,
    output logic signed [7:0]            eng_pixel,
    output logic signed [4:0][4:0][7:0]  eng_weights,
    input  logic                         eng_all_done,
    input  logic [EA-1:0]                eng_wr_addr,
    input  logic signed [31:0]           eng_wr_data,
    input  logic                         eng_wr_en,
    output logic [OA-1:0]                out_wr_addr,
    output logic signed [31:0]           out_wr_data,
    output logic                         out_wr_en
);
    localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int CMAX = (TOTAL_PIXELS > WDOG_CYCLES) ? TOTAL_PIXELS : WDOG_CYCLES;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, START, STREAM, WAIT_DONE, FINISH} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [FW-1:0] f;
    logic last_f, wdog_trip;
    logic [31:0] widx;
    logic [2:0] wr, wc;

    assign last_f = f == FW'(NUM_FILTERS - 1);
    assign widx = 32'(cnt) - 32'd1;
    assign wr = 3'(widx / 5);
    assign wc = 3'(widx % 5);
`ifdef CONV_SEQ_WATCHDOG_EN
    assign wdog_trip = state == WAIT_DONE && !eng_all_done && cnt == CW'(WDOG_CYCLES - 1);
`else
    assign wdog_trip = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nxt;

    // next state and per-state memory/engine strobes
    always_comb begin
        state_nxt = state;
        wgt_rd_addr = '0;
        img_rd_en = 1'b0;
        img_rd_addr = '0;
        eng_start = 1'b0;
        eng_data_valid = 1'b0;
        eng_pixel = '0;
        busy = state != IDLE;
        layer_done = state == FINISH;
        case (state)
            IDLE: state_nxt = go ? LOAD_W : IDLE;
            LOAD_W: begin
                wgt_rd_addr = (cnt < CW'(25)) ? WA'(32'(f) * 25 + 32'(cnt)) : '0;
                state_nxt = (cnt == CW'(25)) ? START : LOAD_W;
            end
            START: begin
                eng_start = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                img_rd_en = cnt < CW'(TOTAL_PIXELS);
                img_rd_addr = img_rd_en ? IA'(cnt) : '0;
                eng_data_valid = cnt != '0;
                eng_pixel = eng_data_valid ? img_rd_data : '0;
                state_nxt = (cnt == CW'(TOTAL_PIXELS)) ? WAIT_DONE : STREAM;
            end
            WAIT_DONE: state_nxt = eng_all_done ? (last_f ? FINISH : LOAD_W) : (wdog_trip ? IDLE : WAIT_DONE);
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // per-state step counter (restarts on every transition) and filter index
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt <= '0;
            f <= '0;
        end else begin
            cnt <= (state_nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
            f <= (state == IDLE) ? '0 : (state == WAIT_DONE && eng_all_done && !last_f) ? f + 1'b1 : f;
        end

`ifdef CONV_SEQ_WATCHDOG_EN
    // sticky watchdog flag, cleared when the next layer is accepted
    always_ff @(posedge clk or negedge rst)
        if (!rst) err <= 1'b0;
        else err <= (state == IDLE && go) ? 1'b0 : (err | wdog_trip);
`else
    assign err = 1'b0;
`endif

    // capture the ROM word requested on the previous cycle into its row-major slot
    always_ff @(posedge clk or negedge rst)
        if (!rst) eng_weights <= '0;
        else if (state == LOAD_W && cnt != '0) eng_weights[wr][wc] <= wgt_rd_data;

    // relocate engine write-backs into the active filter's slab, one cycle later
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            out_wr_addr <= '0;
            out_wr_data <= '0;
            out_wr_en <= 1'b0;
        end else begin
            out_wr_addr <= OA'(32'(f) * OUT_PIXELS + 32'(eng_wr_addr));
            out_wr_data <= eng_wr_data;
            out_wr_en <= eng_wr_en;
        end
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: scripted engine and memories against a cycle-level model of one layer
`timescale 1ns/1ps
module tb_conv_layer_sequencer;
    localparam int MS = 8;
    localparam int NF = 2;
    localparam int WD = 100;
    localparam int TOT = MS * MS;
    localparam int OPX = (MS - 4) * (MS - 4);
    localparam int P = 28 + TOT + 10;
    localparam int WD_END = 28 + TOT + WD;

    logic clk = 0, rst = 0, go = 0;
    logic busy, layer_done, err;
    logic [5:0] wgt_rd_addr;
    logic signed [7:0] wgt_rd_data = 0;
    logic [5:0] img_rd_addr;
    logic img_rd_en;
    logic signed [7:0] img_rd_data = 0;
    logic eng_start, eng_data_valid;
    logic signed [7:0] eng_pixel;
    logic signed [4:0][4:0][7:0] eng_weights;
    logic eng_all_done = 0;
    logic [3:0] eng_wr_addr = 0;
    logic signed [31:0] eng_wr_data = 0;
    logic eng_wr_en = 0;
    logic [4:0] out_wr_addr;
    logic signed [31:0] out_wr_data;
    logic out_wr_en;

    logic signed [7:0] img [TOT];
    int cyc = 0, t0 = 0, tests = 0, fails = 0;
    int vld_cnt = 0, ld_cnt = 0, wr_cnt = 0, last_oa = -1;
    bit act = 0, wd = 0, sticky = 0;

    conv_layer_sequencer #(.MAPSIZE(MS), .NUM_FILTERS(NF), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .layer_done(layer_done), .err(err),
        .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .img_rd_addr(img_rd_addr), .img_rd_en(img_rd_en), .img_rd_data(img_rd_data),
        .eng_start(eng_start), .eng_data_valid(eng_data_valid), .eng_pixel(eng_pixel),
        .eng_weights(eng_weights), .eng_all_done(eng_all_done),
        .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data), .eng_wr_en(eng_wr_en),
        .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data), .out_wr_en(out_wr_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) wgt_rd_data <= 8'(wgt_rd_addr);
    always @(posedge clk) if (img_rd_en) img_rd_data <= img[img_rd_addr];

    function automatic int wdata(int n, int i);
        return 1000 * n + 7 * i - 50;
    endfunction

    // engine write scheduled at relative cycle s: returns n*OPX+i, or -1
    function automatic int wr_slot(int s);
        int n, i;
        if (s < 0) return -1;
        n = s / P;
        i = s % P - (P - OPX);
        return (n < NF && i >= 0) ? n * OPX + i : -1;
    endfunction

    // done rises on a filter's last WAIT_DONE cycle and lingers into the next LOAD_W
    function automatic bit done_at(int s);
        for (int n = 0; n < NF; n++) if (s - n * P >= P - 1 && s - n * P <= P + 9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    initial forever begin : drv
        int s, k;
        @(posedge clk);
        #2;
        s = cyc - t0;
        k = (act && !wd) ? wr_slot(s) : -1;
        eng_wr_en = k >= 0;
        eng_wr_addr = (k >= 0) ? 4'(k % OPX) : 4'd0;
        eng_wr_data = (k >= 0) ? wdata(k / OPX, k % OPX) : 0;
        eng_all_done = act && !wd && done_at(s);
    end

    always @(negedge clk) begin : cmp
        int r, n, q, j, k, e_wa, e_ia, e_od;
        bit on, fp, e_ren, e_dv, e_err;
        logic signed [7:0] e_px;
        logic signed [4:0][4:0][7:0] ew;
        r = cyc - t0;
        on = act && rst && r >= 0 && r < (wd ? WD_END : NF * P + 1);
        fp = on && (wd || r < NF * P);
        n = wd ? 0 : r / P;
        q = wd ? r : r % P;
        j = q - 27;
        e_wa = (fp && q < 25) ? n * 25 + q : 0;
        e_ren = fp && j >= 0 && j < TOT;
        e_ia = e_ren ? j : 0;
        e_dv = fp && j >= 1 && j <= TOT;
        e_px = e_dv ? img[j - 1] : 8'sd0;
        e_err = !act ? 1'b0 : (r < 0) ? sticky : (wd && r >= WD_END);
        k = (act && !wd && rst) ? wr_slot(r - 1) : -1;
        e_od = (k >= 0) ? wdata(k / OPX, k % OPX) : 0;
        chk("busy", busy, on);
        chk("layer_done", layer_done, on && !wd && r == NF * P);
        chk("err", err, e_err);
        chk("wgt_rd_addr", wgt_rd_addr, e_wa);
        chk("eng_start", eng_start, fp && q == 26);
        chk("img_rd_en", img_rd_en, e_ren);
        chk("img_rd_addr", img_rd_addr, e_ia);
        chk("eng_data_valid", eng_data_valid, e_dv);
        chk("eng_pixel", eng_pixel, e_px);
        chk("out_wr_en", out_wr_en, k >= 0);
        if (k >= 0) begin
            chk("out_wr_addr", out_wr_addr, k);
            chk("out_wr_data", out_wr_data, e_od);
        end
        if (fp && q >= 26) begin
            for (int a = 0; a < 5; a++)
                for (int b = 0; b < 5; b++) ew[a][b] = 8'(n * 25 + 5 * a + b);
            chk("eng_weights", eng_weights, ew);
        end
        if (on && !wd) begin
            if (r == 26) chk("start_at_T27", eng_start, 1);
            if (r == 27) chk("no_valid_at_T28", eng_data_valid, 0);
            if (r == 28) chk("first_valid_T29", eng_data_valid, 1);
            if (r == 91) chk("last_valid_T92", eng_data_valid, 1);
            if (r == 90) chk("last_img_addr", img_rd_addr, 63);
            if (r == 30) chk("w44_filter0", eng_weights[4][4], 24);
            if (r == P + 60) chk("w23_filter1", eng_weights[2][3], 38);
        end
        vld_cnt += int'(eng_data_valid);
        ld_cnt += int'(layer_done);
        wr_cnt += int'(out_wr_en);
        if (out_wr_en) last_oa = int'(out_wr_addr);
    end

    task automatic launch(input bit w);
        @(posedge clk);
        #1;
        vld_cnt = 0;
        ld_cnt = 0;
        wr_cnt = 0;
        last_oa = -1;
        wd = w;
        t0 = cyc + 1;
        act = 1;
        go = 1;
        @(posedge clk);
        #1 go = 0;
    endtask

    task automatic layer;
        launch(0);
        repeat (39) @(posedge clk);
        #1 go = 1;
        @(posedge clk);
        #1 go = 0;
        repeat (NF * P - 36) @(posedge clk);
    endtask

    task automatic check_layer;
        chk("valid_count", vld_cnt, 128);
        chk("done_pulses", ld_cnt, 1);
        chk("write_count", wr_cnt, 32);
        chk("last_out_addr", last_oa, 31);
    endtask

    initial begin
        for (int i = 0; i < TOT; i++) img[i] = 8'($urandom_range(0, 255));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_weights", eng_weights, '0);
        chk("rst_busy", busy, 0);
        rst = 1;
        layer();
        check_layer();
        launch(0);
        repeat (50) @(posedge clk);
        #1;
        rst = 0;
        act = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", eng_data_valid, 0);
        chk("midrst_img_en", img_rd_en, 0);
        chk("midrst_weights", eng_weights, '0);
        @(posedge clk);
        #1 rst = 1;
        layer();
        check_layer();
`ifdef CONV_SEQ_WATCHDOG_EN
        launch(1);
        repeat (WD_END + 3) @(posedge clk);
        #1;
        chk("wdog_err", err, 1);
        chk("wdog_idle", busy, 0);
        chk("wdog_no_done", ld_cnt, 0);
        sticky = 1;
        layer();
        check_layer();
        chk("err_cleared", err, 0);
        sticky = 0;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Controller that runs `conv_engine` over a full layer of `NUM_FILTERS` 5x5 filters on one `MAPSIZE`x`MAPSIZE` input map. For each filter it does four things in order:
- loads the 25 weights from a weight ROM;
- pulses the engine start;
- streams every input pixel from the feature-map RAM;
- waits for `all_done` before moving to the next filter.

Engine write-backs are relocated into a single layer-wide output buffer, one `OUTPUT_DIM`² slab per filter.

## Interface
Parameters:
- `MAPSIZE`, 32, input map edge; `OUTPUT_DIM` = `MAPSIZE`-4, `TOTAL_PIXELS` = `MAPSIZE`², `OUT_PIXELS` = `OUTPUT_DIM`²
- `NUM_FILTERS`, 6, filters per layer
- `WDOG_CYCLES`, 4096, watchdog limit (used only with `CONV_SEQ_WATCHDOG_EN`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `go`  in  1  start-layer request, sampled in IDLE only
- `busy`  out  1  high from the cycle after `go` is accepted until return to IDLE
- `layer_done`  out  1  one-cycle pulse after the last filter completes
- `err`  out  1  sticky watchdog error, cleared by the next accepted `go`
- `wgt_rd_addr`  out  $clog2(`NUM_FILTERS`*25)  weight ROM address; ROM read latency is 1 cycle
- `wgt_rd_data`  in  8 signed  weight ROM data
- `img_rd_addr`  out  $clog2(`TOTAL_PIXELS`)  feature-map RAM address; RAM read latency is 1 cycle
- `img_rd_en`  out  1  feature-map read enable
- `img_rd_data`  in  8 signed  pixel data
- `eng_start`  out  1  to engine `start`
- `eng_data_valid`  out  1  to engine `data_valid_in`
- `eng_pixel`  out  8 signed  to engine `pixel_in`
- `eng_weights`  out  [4:0][4:0] x 8 signed  to engine `weights`
- `eng_all_done`  in  1  from engine `all_done`
- `eng_wr_addr`  in  $clog2(`OUT_PIXELS`)  from engine `mem_wr_addr`
- `eng_wr_data`  in  32 signed  from engine `mem_wr_data`
- `eng_wr_en`  in  1  from engine `mem_wr_en`
- `out_wr_addr`  out  $clog2(`NUM_FILTERS`*`OUT_PIXELS`)  layer buffer address
- `out_wr_data`  out  32 signed  layer buffer data
- `out_wr_en`  out  1  layer buffer write enable

## Operation
- States: IDLE → LOAD_W → START → STREAM → WAIT_DONE → (LOAD_W for the next filter | FINISH) → IDLE.
- IDLE:
  - `go`=1 moves to LOAD_W.
  - Filter index f is set to 0 and `err` is cleared.
  - `go` in any other state is ignored.
- LOAD_W (26 cycles, k = 0..25):
  - For k<25: issue `wgt_rd_addr` = f*25+k.
  - For k≥1: capture `wgt_rd_data` into `eng_weights[(k-1)/5][(k-1)%5]`, row-major.
- START: `eng_start`=1 for exactly one cycle.
- STREAM (`TOTAL_PIXELS`+1 cycles, j = 0..`TOTAL_PIXELS`):
  - For j<`TOTAL_PIXELS`: `img_rd_en`=1 and `img_rd_addr`=j.
  - For j≥1: `eng_data_valid`=1 and `eng_pixel` = `img_rd_data`.
  - Valid is high for exactly `TOTAL_PIXELS` consecutive cycles, in raster order.
- WAIT_DONE:
  - Hold until `eng_all_done`=1.
  - If f = `NUM_FILTERS`-1, go to FINISH; otherwise increment f and go to LOAD_W.
- FINISH: `layer_done`=1 for one cycle, then IDLE.
- `eng_weights` changes only in LOAD_W and is stable from START through WAIT_DONE.
- Write relocation:
  - `out_wr_addr` = f*`OUT_PIXELS` + `eng_wr_addr`.
  - `out_wr_data` = `eng_wr_data`.
  - `out_wr_en` = `eng_wr_en`.
  - All three are registered, with a 1-cycle latency.
  - f for a write is the filter active when the write was sampled.
- Arithmetic: every address computation uses unsigned arithmetic at the full output width; there is no wrap within a layer.

## Timing
- Reset value of every output is 0: `busy`, `layer_done`, `err`, all addresses, enables, `eng_*`, `eng_weights`, `out_*`. State goes to IDLE and f to 0.
- Reset mid-layer:
  - Returns to IDLE immediately, with no `layer_done` pulse.
  - The engine is reset separately by its own reset; this block does not drive it.
- `go` accepted at edge T:
  - `busy`=1 from T+1.
  - First `wgt_rd_addr` at T+1.
  - `eng_start` at T+27.
  - First `eng_data_valid` at T+29; last at T+28+`TOTAL_PIXELS`.
- Per-filter overhead outside WAIT_DONE: 26 + 1 + `TOTAL_PIXELS`+1 cycles.
- `eng_all_done` is sampled only in WAIT_DONE; a level held over from the previous filter is not seen, because at least 28 cycles pass before WAIT_DONE is re-entered.
- An engine write concurrent with the `eng_all_done` state transition still uses the old f.

## Configuration
- `CONV_SEQ_WATCHDOG_EN` defined:
  - A counter runs in WAIT_DONE.
  - If `eng_all_done` is not seen within `WDOG_CYCLES` cycles: `err`←1 (sticky), go to IDLE, `busy`←0, no `layer_done` pulse.
- Undefined: WAIT_DONE waits indefinitely, `err` is tied to 0, and `WDOG_CYCLES` is unused.

## Test plan
- `MAPSIZE`=8, `NUM_FILTERS`=2, random weights/image, real `conv_engine` attached → 32 writes. `out_wr_addr` 0..15 match the golden filter 0 and 16..31 match golden filter 1; `layer_done` pulses once; `busy` drops on the same edge.
- Cycle check with `go` at T → `eng_start` at T+27; `eng_data_valid` high T+29..T+92 (64 cycles); `img_rd_addr` 0..63 in order.
- Weight ROM with value = address → `eng_weights[r][c]` = 25+5r+c during filter 1, stable across STREAM.
- `go` pulsed during STREAM, plus `eng_all_done` held high in LOAD_W → no effect; exactly 2 filters are processed.
- `rst`=0 mid-STREAM → all outputs 0 next cycle; a fresh `go` completes a correct layer.
- With `CONV_SEQ_WATCHDOG_EN` and `WDOG_CYCLES`=100, engine stub never asserting done → `err`=1 after 100 WAIT_DONE cycles, return to IDLE, no `layer_done`; the next `go` clears `err`.
